pu_fifo: RTL and testbench
==========================

// Module: pu_fifo
// PURPOSE
//   Buffering processing unit on the shared NITTA data bus. It stores up to DEPTH
//   words written from the bus, such as results driven by pu_mux during its oe
//   cycles, and returns them in order when the controller asserts signal_oe.
//   Its outputs are OR-merged onto the bus, so it drives zeros whenever it is not
//   selected.
// PARAMETERS
//   W       32  data word width
//   WA      4   attribute width; bit 0 is the INVALID flag
//   ADDR_W  3   pointer width; DEPTH = 1 << ADDR_W entries
// PORTS
//   clk           in   1       system clock, all state updates on rising edge
//   rst           in   1       synchronous active-high reset
//   signal_wr     in   1       push {attr_in, data_in} at this edge
//   data_in       in   W       bus data
//   attr_in       in   WA      bus attributes, stored alongside the data
//   signal_oe     in   1       drive head entry to bus this cycle; pop at edge
//   data_out      out  W       head data while signal_oe, else 0
//   attr_out      out  WA      head attributes while signal_oe, else 0
//   full          out  1       count == DEPTH
//   empty         out  1       count == 0
//   err           out  1       sticky; set on overflow or underflow
// BEHAVIOUR
//   - State: storage array [DEPTH] of W+WA bits, wr_ptr/rd_ptr (ADDR_W bits),
//     count (ADDR_W+1 bits), err register.
//   - Reset (rst high at an edge): wr_ptr = rd_ptr = count = 0 and err = 0.
//     Storage contents are don't-care. After the edge: empty = 1, full = 0, err = 0.
//     rst overrides wr/oe in the same cycle; a mid-operation reset discards all entries.
//   - Output timing: data_out/attr_out are combinational from signal_oe and head storage,
//     with zero latency in the oe cycle.
//     - not oe: both outputs are 0.
//     - oe with count > 0: data_out = head data, attr_out = head attr.
//     - oe with count == 0 (underflow): data_out = 0, attr_out = 1 (INVALID only);
//       err is set at the edge and no pointers move.
//   - Push (signal_wr): if not full, or if full with a simultaneous valid pop, store
//     at wr_ptr and advance wr_ptr modulo DEPTH.
//     If full with no pop, the write is dropped, err is set, and state is otherwise unchanged.
//   - Pop (signal_oe with count > 0): advance rd_ptr modulo DEPTH at the edge.
//   - Count update: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
//   - Simultaneous wr+oe while empty: the read underflows (INVALID, err set) and the
//     write is stored, so count becomes 1. There is no write-through to the output.
//   - Simultaneous wr+oe while full: the head is output and popped, the new word is stored,
//     count stays DEPTH, and err is not set.
//   - Pointer wrap: pointers wrap silently from DEPTH-1 to 0. full/empty derive from
//     count only, never from pointer equality.
//   - err clears only on rst.
//   - Attributes pass through unchanged. A stored INVALID bit from upstream is reproduced on read.
// TESTING
//   1. rst for 2 cycles -> empty=1, full=0, err=0; data_out=0 and attr_out=0 with oe low.
//   2. Push 0xA1,0xA2,0xA3,0xA4 (attr 0), then oe for 4 cycles -> data_out sequence
//      A1,A2,A3,A4 with attr_out 0; then empty=1, err=0.
//   3. Push 8 words 0x10..0x17 -> full=1. Push 0x99 -> dropped, err=1.
//      Drain -> 0x10..0x17, with no 0x99.
//   4. oe while empty -> data_out=0, attr_out=1, err=1, count stays 0.
//      Same-cycle wr of 0x55 -> a later oe returns 0x55.
//   5. Fill to 8, then hold wr+oe for 12 cycles with data 0x20..0x2B -> count stays 8,
//      output order is continuous across pointer wrap, err=0.
//   6. Push 3 words, assert rst during an oe cycle -> empty=1, err=0.
//      The next oe yields an underflow (attr_out=1).

Source files
------------

// File: rtl/pu_fifo.sv
// rtl/pu_fifo.sv - in-order word buffer for the OR-merged NITTA data bus
// Outputs are zero unless signal_oe selects this unit, so they can be ORed onto the bus.
module pu_fifo #(
    parameter int W      = 32,
    parameter int WA     = 4,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          signal_wr,
    input  logic [W-1:0]  data_in,
    input  logic [WA-1:0] attr_in,
    input  logic          signal_oe,
    output logic [W-1:0]  data_out,
    output logic [WA-1:0] attr_out,
    output logic          full,
    output logic          empty,
    output logic          err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int EW    = W + WA;
    localparam logic [ADDR_W:0] COUNT_FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [WA-1:0]   ATTR_INVALID = WA'(1);

    // Each entry holds {attr, data}; contents need no reset.
    logic [EW-1:0]     mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic          is_full;
    logic          is_empty;
    logic          do_pop;
    logic          do_push;
    logic          underflow;
    logic          overflow;
    logic [EW-1:0] head;

    assign is_full   = (count_q == COUNT_FULL);
    assign is_empty  = (count_q == '0);
    assign do_pop    = signal_oe && !is_empty;
    assign underflow = signal_oe && is_empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push   = signal_wr && (!is_full || do_pop);
    assign overflow  = signal_wr && is_full && !do_pop;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q || underflow || overflow;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= {attr_in, data_in};
        end
    end

    // An underflowing read presents a lone INVALID flag instead of stale storage.
    always_comb begin
        data_out = '0;
        attr_out = '0;
        if (do_pop) begin
            data_out = head[W-1:0];
            attr_out = head[EW-1:W];
        end else if (underflow) begin
            attr_out = ATTR_INVALID;
        end
    end

    assign full  = is_full;
    assign empty = is_empty;
    assign err   = err_q;
endmodule

// File: tb/tb_pu_fifo.sv
// tb/tb_pu_fifo.sv - directed bench for pu_fifo with a queue-based reference model
module tb_pu_fifo;
    logic        clk;
    logic        rst;
    logic        signal_wr;
    logic [31:0] data_in;
    logic [3:0]  attr_in;
    logic        signal_oe;
    logic [31:0] data_out;
    logic [3:0]  attr_out;
    logic        full;
    logic        empty;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    pu_fifo #(.W(32), .WA(4), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .signal_wr (signal_wr),
        .data_in   (data_in),
        .attr_in   (attr_in),
        .signal_oe (signal_oe),
        .data_out  (data_out),
        .attr_out  (attr_out),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {attr, data}, capacity 8.
    logic [35:0] mq[$];
    bit          m_err;
    bit          model_valid = 0;

    always @(posedge clk) begin
        bit pop_ok;
        if (rst) begin
            mq.delete();
            m_err = 0;
            model_valid = 1;
        end else if (model_valid) begin
            pop_ok = signal_oe && (mq.size() > 0);
            if (signal_oe && mq.size() == 0) m_err = 1;
            if (pop_ok) void'(mq.pop_front());
            if (signal_wr) begin
                if (mq.size() < 8) mq.push_back({attr_in, data_in});
                else m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        logic [3:0]  ea;
        if (model_valid) begin
            ed = '0;
            ea = '0;
            if (signal_oe) begin
                if (mq.size() > 0) begin
                    ed = mq[0][31:0];
                    ea = mq[0][35:32];
                end else begin
                    ea = 4'h1;
                end
            end
            check("cmp_data_out", 64'(data_out), 64'(ed));
            check("cmp_attr_out", 64'(attr_out), 64'(ea));
            check("cmp_full", 64'(full), 64'(mq.size() == 8));
            check("cmp_empty", 64'(empty), 64'(mq.size() == 0));
            check("cmp_err", 64'(err), 64'(m_err));
        end
    end

    // Apply one cycle of inputs just after a rising edge, return at the following falling edge.
    task automatic cyc(input logic r, input logic wr, input logic [31:0] d,
                       input logic [3:0] a, input logic oe);
        @(posedge clk);
        #1;
        rst       = r;
        signal_wr = wr;
        data_in   = d;
        attr_in   = a;
        signal_oe = oe;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; signal_wr = 1'b0; data_in = '0; attr_in = '0; signal_oe = 1'b0;

        // 1: reset
        cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        idle();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_attr_out", 64'(attr_out), 64'd0);

        // 2: four words in, four out
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'hA1 + 32'(i), 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
            check("t2_data", 64'(data_out), 64'hA1 + 64'(i));
            check("t2_attr", 64'(attr_out), 64'd0);
        end
        idle();
        check("t2_empty", 64'(empty), 64'd1);
        check("t2_err", 64'(err), 64'd0);

        // 3: fill, overflow drop, drain
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h10 + 32'(i), 4'h0, 1'b0);
        idle();
        check("t3_full", 64'(full), 64'd1);
        check("t3_err_before", 64'(err), 64'd0);
        cyc(1'b0, 1'b1, 32'h99, 4'h0, 1'b0);
        idle();
        check("t3_err_overflow", 64'(err), 64'd1);
        check("t3_still_full", 64'(full), 64'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
            check("t3_drain", 64'(data_out), 64'h10 + 64'(i));
        end
        idle();
        check("t3_empty", 64'(empty), 64'd1);

        // 4: underflow, then wr+oe while empty, then attribute passthrough
        cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        check("t4_uf_data", 64'(data_out), 64'd0);
        check("t4_uf_attr", 64'(attr_out), 64'd1);
        idle();
        check("t4_uf_err", 64'(err), 64'd1);
        check("t4_uf_empty", 64'(empty), 64'd1);
        cyc(1'b0, 1'b1, 32'h55, 4'h0, 1'b1);
        check("t4_wroe_attr", 64'(attr_out), 64'd1);
        check("t4_wroe_data", 64'(data_out), 64'd0);
        idle();
        check("t4_count1", 64'(empty), 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        check("t4_read55", 64'(data_out), 64'h55);
        check("t4_read55_attr", 64'(attr_out), 64'd0);
        cyc(1'b0, 1'b1, 32'h66, 4'hB, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        check("t4_attr_pass_data", 64'(data_out), 64'h66);
        check("t4_attr_pass_attr", 64'(attr_out), 64'hB);
        idle();
        check("t4_empty", 64'(empty), 64'd1);

        // 5: full with continuous wr+oe across pointer wrap
        cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h30 + 32'(i), 4'h0, 1'b0);
        idle();
        check("t5_full", 64'(full), 64'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 32'h20 + 32'(i), 4'h0, 1'b1);
            check("t5_stream", 64'(data_out), (i < 8) ? 64'h30 + 64'(i) : 64'h20 + 64'(i - 8));
            check("t5_stream_full", 64'(full), 64'd1);
        end
        idle();
        check("t5_full_after", 64'(full), 64'd1);
        check("t5_err", 64'(err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
            check("t5_drain", 64'(data_out), 64'h24 + 64'(i));
        end
        idle();
        check("t5_empty", 64'(empty), 64'd1);

        // 6: reset during an oe cycle discards contents
        cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h40 + 32'(i), 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b1);
        check("t6_head_before_rst", 64'(data_out), 64'h40);
        idle();
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_err", 64'(err), 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        check("t6_uf_attr", 64'(attr_out), 64'd1);
        check("t6_uf_data", 64'(data_out), 64'd0);
        idle();
        check("t6_uf_err", 64'(err), 64'd1);

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
